// File: rtl/run_stuffer.sv
// Serial bit-stuffing transmitter: after every MAX_RUN identical output bits it
// inserts a complemented stuff bit so no run on the line exceeds MAX_RUN.
module run_stuffer #(
  parameter int MAX_RUN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  input  logic in_valid,
  output logic in_ready,
  output logic out_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic out_stuff
);

  localparam int CW = (MAX_RUN < 1) ? 1 : $clog2(MAX_RUN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(MAX_RUN);
  localparam logic [CW-1:0] RUN_ONE = CW'(1);

  // Handshake: a bit moves on a rising edge only when valid & ready are both
  // high in that cycle; in_ready is combinational, out_valid/out_bit/out_stuff
  // are registered and hold stable while out_valid & ~out_ready.
  logic            last_bit;
  logic [CW-1:0]   run_cnt;
  logic            load_ok;
  logic            need_stuff;

  assign load_ok    = ~out_valid | out_ready;
  assign need_stuff = (run_cnt == RUN_MAX);
  assign in_ready   = load_ok & ~need_stuff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      out_stuff <= 1'b0;
      last_bit  <= 1'b0;
      run_cnt   <= '0;
    end else if (load_ok) begin
      if (need_stuff) begin
        // The stuff bit opens a new run, so following data can extend it.
        out_bit   <= ~last_bit;
        out_stuff <= 1'b1;
        out_valid <= 1'b1;
        last_bit  <= ~last_bit;
        run_cnt   <= RUN_ONE;
      end else if (in_valid) begin
        out_bit   <= in_bit;
        out_stuff <= 1'b0;
        out_valid <= 1'b1;
        if (in_bit == last_bit && run_cnt != '0) begin
          run_cnt <= run_cnt + RUN_ONE;
        end else begin
          run_cnt  <= RUN_ONE;
          last_bit <= in_bit;
        end
      end else begin
        // Idle gaps leave the run history untouched.
        out_valid <= 1'b0;
      end
    end
  end

endmodule
